// File: rtl/daq_pkg.sv
// rtl/daq_pkg.sv - shared word width, abort terminator and arbiter state type
package daq_pkg;
   localparam int DAQ_WORD_W = 32;
   localparam logic [DAQ_WORD_W-1:0] ABORT_WORD = 32'hDEAD0000;
   typedef enum logic {IDLE, BUSY} arb_state_t;
endpackage

// File: rtl/daq_fifo.sv
// rtl/daq_fifo.sv - show-ahead FIFO with fill count; head reads as zero while empty
module daq_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   fill
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full;
   logic             do_pop;

   assign full   = (fill == FULL_CNT);
   assign valid  = (fill != '0);
   assign do_pop = pop && valid;
   assign rdata  = valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, do_pop})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase
      end
   end

   // The arbiter only grants with room for a worst-case packet, so this must never fire.
   always_ff @(posedge clk) begin
      if (!rst) assert (!(push && full));
   end
endmodule

// File: rtl/daq_arbiter.sv
// rtl/daq_arbiter.sv - round-robin DAQ stream arbiter with framing checks and packet FIFO
module daq_arbiter
   import daq_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int DEPTH   = 16,
   parameter int MAX_PKT = 4,
   parameter int TIMEOUT = 64,
   parameter logic [DAQ_WORD_W-1:0] ABORT_WORD = daq_pkg::ABORT_WORD
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NREQ-1:0]              daq_req,
   output logic [NREQ-1:0]              daq_grant,
   input  logic [NREQ*DAQ_WORD_W-1:0]   daq_data,
   input  logic [NREQ-1:0]              daq_valid,
   input  logic [NREQ-1:0]              daq_end,
   output logic [DAQ_WORD_W-1:0]        out_data,
   output logic                         out_end,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         err_timeout,
   output logic                         err_overlen,
   output logic                         err_stray
);
   localparam int OW  = $clog2(NREQ);
   localparam int WCW = $clog2(MAX_PKT + 1);
   localparam int TCW = $clog2(TIMEOUT + 1);
   localparam int FW  = $clog2(DEPTH) + 1;
   localparam logic [WCW-1:0] WC_MAX     = WCW'(MAX_PKT);
   localparam logic [TCW-1:0] TC_MAX     = TCW'(TIMEOUT);
   localparam logic [FW-1:0]  FILL_LIMIT = FW'(DEPTH - MAX_PKT - 1);
   localparam logic [OW+1:0]  NREQ_W     = (OW+2)'(NREQ);

   arb_state_t          state, state_nxt;
   logic [OW-1:0]       owner, last_owner, pick;
   logic [WCW-1:0]      wcnt;
   logic [TCW-1:0]      tcnt;
   logic [FW-1:0]       fill;
   logic                fifo_valid, push, done, start_grant, cnt_word;
   logic                ev_timeout, ev_overlen, ev_stray;
   logic [DAQ_WORD_W:0] push_word, head_word;
   logic [NREQ-1:0]     owner_mask;
   logic                own_valid, own_end;
   logic [DAQ_WORD_W-1:0] own_data;

   logic [OW:0]         rr_start;
   logic [2*NREQ-1:0]   rr_dbl;
   logic [NREQ-1:0]     rr_rot;
   logic [OW-1:0]       rr_off;
   logic [OW+1:0]       rr_sum;

   // Rotate so the slot after last_owner sits at bit 0, take the lowest request, rotate back.
   always_comb begin
      rr_start = {1'b0, last_owner} + 1'b1;
      rr_dbl   = {daq_req, daq_req} >> rr_start;
      rr_rot   = rr_dbl[NREQ-1:0];
      rr_off   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rr_rot[i]) rr_off = OW'(i);
      end
      rr_sum = {1'b0, rr_start} + {2'b0, rr_off};
      if (rr_sum >= NREQ_W) rr_sum = rr_sum - NREQ_W;
      pick = rr_sum[OW-1:0];
   end

   assign owner_mask  = (state == BUSY) ? (NREQ'(1) << owner) : '0;
   assign own_valid   = daq_valid[owner];
   assign own_end     = daq_end[owner];
   assign own_data    = daq_data[owner*DAQ_WORD_W +: DAQ_WORD_W];
   assign start_grant = (|daq_req) && (fill <= FILL_LIMIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_grant) state_nxt = BUSY;
         BUSY:    if (done)        state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // An end word on the deadline cycle still closes the packet normally; otherwise the deadline wins.
   always_comb begin
      push       = 1'b0;
      push_word  = {1'b1, ABORT_WORD};
      cnt_word   = 1'b0;
      done       = 1'b0;
      ev_timeout = 1'b0;
      ev_overlen = 1'b0;
      ev_stray   = |(daq_valid & ~owner_mask);
      if (state == BUSY) begin
         if (own_valid && own_end) begin
            push = 1'b1;
            done = 1'b1;
            if (wcnt < WC_MAX) begin
               push_word = {1'b1, own_data};
               cnt_word  = 1'b1;
            end else begin
               ev_overlen = 1'b1;
            end
         end else if (tcnt == TC_MAX) begin
            push       = 1'b1;
            done       = 1'b1;
            ev_timeout = 1'b1;
         end else if (own_valid) begin
            if (wcnt < WC_MAX) begin
               push      = 1'b1;
               push_word = {1'b0, own_data};
               cnt_word  = 1'b1;
            end else begin
               ev_overlen = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner       <= '0;
         last_owner  <= OW'(NREQ - 1);
         wcnt        <= '0;
         tcnt        <= '0;
         daq_grant   <= '0;
         err_timeout <= 1'b0;
         err_overlen <= 1'b0;
         err_stray   <= 1'b0;
      end else begin
         daq_grant   <= '0;
         err_timeout <= ev_timeout;
         err_overlen <= ev_overlen;
         err_stray   <= ev_stray;
         if (state == IDLE && start_grant) begin
            owner     <= pick;
            daq_grant <= NREQ'(1) << pick;
            wcnt      <= '0;
            tcnt      <= '0;
         end else if (state == BUSY) begin
            tcnt <= tcnt + 1'b1;
            if (cnt_word) wcnt <= wcnt + 1'b1;
            if (done)     last_owner <= owner;
         end
      end
   end

   daq_fifo #(.WIDTH(DAQ_WORD_W + 1), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (push_word),
      .pop   (out_ready),
      .rdata (head_word),
      .valid (fifo_valid),
      .fill  (fill)
   );

   assign out_valid = fifo_valid;
   assign out_data  = head_word[DAQ_WORD_W-1:0];
   assign out_end   = head_word[DAQ_WORD_W];
endmodule

// File: tb/tb_daq_arbiter.sv
// tb/tb_daq_arbiter.sv - directed vector table plus multi-cycle sequences for daq_arbiter
module tb_daq_arbiter;
   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   daq_req, daq_grant, daq_valid, daq_end;
   logic [127:0] daq_data;
   logic [31:0]  out_data;
   logic         out_end, out_valid, out_ready;
   logic         err_timeout, err_overlen, err_stray;
   logic         ok;
   int           tests = 0;
   int           fails = 0;
   int           ngr, tk;
   logic [32:0]  exp_q[$];

   typedef struct {
      logic [3:0]  req, valid, eop;
      logic [31:0] data;
      logic        ready;
      logic [3:0]  grant;
      logic        ov;
      logic [31:0] od;
      logic        oe;
      logic [2:0]  err;
   } vec_t;
   vec_t vt[11];

   always #5 clk = ~clk;

   daq_arbiter dut (
      .clk(clk), .rst(rst), .daq_req(daq_req), .daq_grant(daq_grant),
      .daq_data(daq_data), .daq_valid(daq_valid), .daq_end(daq_end),
      .out_data(out_data), .out_end(out_end), .out_valid(out_valid), .out_ready(out_ready),
      .err_timeout(err_timeout), .err_overlen(err_overlen), .err_stray(err_stray)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(input int budget, output logic got);
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         step();
         if (daq_grant != 4'b0) got = 1'b1;
      end
   endtask

   task automatic send_word(input int idx, input logic [31:0] d, input logic eop);
      daq_valid = 4'b0001 << idx;
      daq_end   = eop ? daq_valid : 4'b0;
      daq_data  = '0;
      daq_data[idx*32 +: 32] = d;
      step();
      daq_valid = 4'b0;
      daq_end   = 4'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      out_ready = 1'b1;
      while (exp_q.size() > 0 && n < 40) begin
         if (out_valid) check(name, {out_end, out_data}, exp_q.pop_front());
         step();
         n++;
      end
      check({name, "_empty"}, {out_valid, 32'(exp_q.size())}, 64'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      daq_req = 4'b0; daq_valid = 4'b0; daq_end = 4'b0; daq_data = '0; out_ready = 1'b0;
      rst = 1'b1;
      step();
      step();
      check("reset_outputs", {daq_grant, out_valid, out_end, out_data, err_timeout, err_overlen, err_stray}, 64'd0);
      rst = 1'b0;

      //           req     valid   eop     data        rdy   grant   ov    od          oe    err
      vt[0]  = '{4'b0001, 4'b0000, 4'b0000, 32'h0,     1'b1, 4'b0001, 1'b0, 32'h0,     1'b0, 3'b000};
      vt[1]  = '{4'b0000, 4'b0000, 4'b0000, 32'h0,     1'b1, 4'b0000, 1'b0, 32'h0,     1'b0, 3'b000};
      vt[2]  = '{4'b0000, 4'b0001, 4'b0000, 32'h11,    1'b1, 4'b0000, 1'b1, 32'h11,    1'b0, 3'b000};
      vt[3]  = '{4'b0000, 4'b0001, 4'b0001, 32'h22,    1'b1, 4'b0000, 1'b1, 32'h22,    1'b1, 3'b000};
      vt[4]  = '{4'b0000, 4'b0000, 4'b0000, 32'h0,     1'b1, 4'b0000, 1'b0, 32'h0,     1'b0, 3'b000};
      vt[5]  = '{4'b0000, 4'b0010, 4'b0000, 32'h55,    1'b1, 4'b0000, 1'b0, 32'h0,     1'b0, 3'b001};
      vt[6]  = '{4'b0000, 4'b0000, 4'b0000, 32'h0,     1'b1, 4'b0000, 1'b0, 32'h0,     1'b0, 3'b000};
      vt[7]  = '{4'b0011, 4'b0000, 4'b0000, 32'h0,     1'b1, 4'b0010, 1'b0, 32'h0,     1'b0, 3'b000};
      vt[8]  = '{4'b0000, 4'b0100, 4'b0000, 32'h77,    1'b1, 4'b0000, 1'b0, 32'h0,     1'b0, 3'b001};
      vt[9]  = '{4'b0000, 4'b0010, 4'b0010, 32'h33,    1'b1, 4'b0000, 1'b1, 32'h33,    1'b1, 3'b000};
      vt[10] = '{4'b0000, 4'b0000, 4'b0000, 32'h0,     1'b1, 4'b0000, 1'b0, 32'h0,     1'b0, 3'b000};

      for (int i = 0; i < 11; i++) begin
         daq_req = vt[i].req; daq_valid = vt[i].valid; daq_end = vt[i].eop;
         daq_data = {4{vt[i].data}}; out_ready = vt[i].ready;
         step();
         check($sformatf("vec%0d_grant", i), daq_grant, vt[i].grant);
         check($sformatf("vec%0d_valid", i), out_valid, vt[i].ov);
         check($sformatf("vec%0d_err", i), {err_timeout, err_overlen, err_stray}, vt[i].err);
         if (vt[i].ov) check($sformatf("vec%0d_head", i), {out_end, out_data}, {vt[i].oe, vt[i].od});
      end
      daq_req = 4'b0; daq_valid = 4'b0; daq_end = 4'b0; out_ready = 1'b0;

      // All four requesting from reset: order 0,1,2,3, packets back to back in the FIFO
      do_reset();
      daq_req = 4'b1111;
      for (int p = 0; p < 4; p++) begin
         wait_grant(10, ok);
         check($sformatf("rr_grant%0d", p), daq_grant, 4'b0001 << p);
         send_word(p, 32'h100 + p * 2, 1'b0);
         check("rr_grant_pulse", daq_grant, 4'b0);
         exp_q.push_back({1'b0, 32'(32'h100 + p * 2)});
         daq_req[p] = 1'b0;
         send_word(p, 32'h101 + p * 2, 1'b1);
         exp_q.push_back({1'b1, 32'(32'h101 + p * 2)});
      end
      drain("rr_data");

      // Stalled sink: only three 4-word packets fit before grants stop (fill 12)
      out_ready = 1'b0;
      daq_req = 4'b0001;
      ngr = 0;
      for (int p = 0; p < 4; p++) begin
         wait_grant(12, ok);
         if (ok) begin
            ngr++;
            for (int k = 0; k < 4; k++) begin
               send_word(0, 32'hC000 + p * 4 + k, k == 3);
               exp_q.push_back({k == 3, 32'(32'hC000 + p * 4 + k)});
            end
         end
      end
      check("bp_grants", 64'(ngr), 64'd3);
      daq_req = 4'b0;
      drain("bp_data");
      daq_req = 4'b0001;
      wait_grant(5, ok);
      check("bp_resume", ok, 1'b1);
      daq_req = 4'b0;
      send_word(0, 32'hC100, 1'b1);
      exp_q.push_back({1'b1, 32'hC100});
      drain("bp_resume_data");

      // Silent owner: abort at tcnt 64, then the next requester is served
      daq_req = 4'b0110;
      wait_grant(5, ok);
      check("to_grant", daq_grant, 4'b0010);
      daq_req = 4'b0100;
      tk = 0;
      for (int k = 1; k <= 80; k++) begin
         step();
         if (err_timeout) begin
            tk = k;
            break;
         end
      end
      check("to_cycles", 64'(tk), 64'd65);
      check("to_abort", {out_valid, out_end, out_data}, {2'b11, 32'hDEAD0000});
      step();
      check("to_pulse", err_timeout, 1'b0);
      check("to_next_grant", daq_grant, 4'b0100);
      daq_req = 4'b0;
      send_word(2, 32'h2222, 1'b1);
      exp_q.push_back({1'b1, 32'h2222});
      drain("to_data");

      // Six words from owner 3: words 5 and 6 dropped, terminator appended
      out_ready = 1'b0;
      daq_req = 4'b1000;
      wait_grant(5, ok);
      check("ol_grant", daq_grant, 4'b1000);
      daq_req = 4'b0;
      for (int k = 0; k < 6; k++) begin
         send_word(3, 32'hE0 + k, k == 5);
         check($sformatf("ol_err%0d", k), err_overlen, k >= 4);
         if (k < 4) exp_q.push_back({1'b0, 32'(32'hE0 + k)});
      end
      exp_q.push_back({1'b1, 32'hDEAD0000});
      step();
      check("ol_pulse", err_overlen, 1'b0);
      drain("ol_data");

      // Reset in the middle of a grant with data buffered
      out_ready = 1'b0;
      daq_req = 4'b0001;
      wait_grant(5, ok);
      send_word(0, 32'hF1, 1'b0);
      send_word(0, 32'hF2, 1'b1);
      wait_grant(5, ok);
      check("rst_pre", {out_valid, daq_grant}, {1'b1, 4'b0001});
      #2 rst = 1'b1;
      #1 check("rst_async", {out_valid, daq_grant}, 5'b0);
      step();
      rst = 1'b0;
      daq_req = 4'b1111;
      wait_grant(5, ok);
      check("rst_first_grant", daq_grant, 4'b0001);
      daq_req = 4'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
